// File: rtl/fmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fmul_arbiter
// Description : Round-robin front end sharing one single-precision FMUL core
//               between up to four requesters. Two-stage pipeline (operand
//               register -> combinational multiply -> result register) with
//               full valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fmul_arbiter #(
  parameter  int NREQ = 2,
  localparam int ID_W = (NREQ == 2) ? 1 : 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [32*NREQ-1:0] req_a_i,
  input  logic [32*NREQ-1:0] req_b_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_data_o,
  output logic [ID_W-1:0]   resp_id_o,
  output logic              resp_error_o,
  output logic              resp_overflow_o,
  output logic [15:0]       ops_done_o
);

  // Stage 1: operand register
  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_a_q, s1_a_d;
  logic [31:0]     s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;

  // Stage 2: result register
  logic            s2_valid_q, s2_valid_d;
  logic [31:0]     s2_data_q, s2_data_d;
  logic            s2_err_q, s2_err_d;
  logic            s2_ovf_q, s2_ovf_d;
  logic [ID_W-1:0] s2_id_q, s2_id_d;

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [15:0]     ops_done_q, ops_done_d;

  // Pipeline control
  logic            s2_adv, s1_adv;
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_id;
  logic [31:0]     gnt_a, gnt_b;
  logic            req_fire;

  // FMUL core signals
  logic        c_sign;
  logic [7:0]  c_exp;
  logic [23:0] c_frac;
  logic        c_err, c_ovf;
  logic [47:0] prod;
  logic [9:0]  exp_sum;
  logic        unused_bits;

  assign s2_adv = !s2_valid_q || resp_ready_i;
  assign s1_adv = !s1_valid_q || s2_adv;

  // Round-robin search starting at ptr; the reverse scan lets the lowest
  // distance from ptr win because it is assigned last.
  always_comb begin : arb
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (req_valid_i[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  // Operand mux for the granted requester and one-hot ready generation
  always_comb begin
    gnt_a       = '0;
    gnt_b       = '0;
    req_ready_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        gnt_a = req_a_i[32*i +: 32];
        gnt_b = req_b_i[32*i +: 32];
        // rst_n gating keeps ready low for the whole reset window
        req_ready_o[i] = rst_n && s1_adv && gnt_valid;
      end
    end
  end

  assign req_fire = |(req_valid_i & req_ready_o);

  // Combinational FMUL core: special operands first, then normal product
  // with exponent overflow/underflow handling. Denormal inputs count as zero.
  always_comb begin : core
    logic       sa, sb;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    sa = s1_a_q[31];  ea = s1_a_q[30:23];  fa = s1_a_q[22:0];
    sb = s1_b_q[31];  eb = s1_b_q[30:23];  fb = s1_b_q[22:0];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);

    prod    = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    exp_sum = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]} - 10'd127;

    c_sign = sa ^ sb;
    c_exp  = exp_sum[7:0];
    c_frac = prod[47] ? prod[46:23] : prod[45:22];
    c_err  = 1'b0;
    c_ovf  = 1'b0;

    if (a_nan || b_nan) begin
      c_sign = 1'b0;  c_exp = 8'hFF;  c_frac = 24'h800000;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      c_sign = 1'b0;  c_exp = 8'hFF;  c_frac = 24'h800000;
      c_err  = 1'b1;
    end else if (a_inf || b_inf) begin
      c_exp = 8'hFF;  c_frac = '0;
    end else if (a_zero || b_zero) begin
      c_exp = 8'h00;  c_frac = '0;
    end else if (exp_sum[9] || (exp_sum == 10'd0)) begin
      // underflow flushes to signed zero
      c_exp = 8'h00;  c_frac = '0;
    end else if (exp_sum[8] || (exp_sum[7:0] == 8'hFF)) begin
      c_exp = 8'hFF;  c_frac = '0;
      c_ovf = 1'b1;
    end
  end

  // Guard bit and low product bits are discarded: rounding is truncation
  assign unused_bits = ^{c_frac[0], prod[21:0]};

  // Next-state for both stages, pointer and handshake counter
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;
    s2_ovf_d   = s2_ovf_q;
    s2_id_d    = s2_id_q;
    ptr_d      = ptr_q;
    ops_done_d = ops_done_q;

    if (s1_adv) begin
      s1_valid_d = gnt_valid;
      s1_a_d     = gnt_a;
      s1_b_d     = gnt_b;
      s1_id_d    = gnt_id;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = {c_sign, c_exp, c_frac[23:1]};
      s2_err_d   = c_err;
      s2_ovf_d   = c_ovf;
      s2_id_d    = s1_id_q;
    end
    if (req_fire) begin
      ptr_d = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
    if (s2_valid_q && resp_ready_i) begin
      ops_done_d = ops_done_q + 16'd1;
    end
  end

  // State registers; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_id_q    <= '0;
      ptr_q      <= '0;
      ops_done_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_id_q    <= s2_id_d;
      ptr_q      <= ptr_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign resp_valid_o    = s2_valid_q;
  assign resp_data_o     = s2_data_q;
  assign resp_id_o       = s2_id_q;
  assign resp_error_o    = s2_err_q;
  assign resp_overflow_o = s2_ovf_q;
  assign ops_done_o      = ops_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fmul_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fmul_arbiter
// Description : Directed bench for fmul_arbiter (NREQ=2): vector table of
//               hand-computed products plus arbitration, stall and reset
//               sequences. A response scoreboard checks order, id and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmul_arbiter;
  localparam int NREQ = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [32*NREQ-1:0] req_a, req_b;
  logic            resp_valid, resp_ready;
  logic [31:0]     resp_data;
  logic [0:0]      resp_id;
  logic            resp_error, resp_overflow;
  logic [15:0]     ops_done;

  fmul_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_id_o(resp_id),
    .resp_error_o(resp_error), .resp_overflow_o(resp_overflow),
    .ops_done_o(ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rq;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        e;
    logic        o;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] d;
    logic        e;
    logic        o;
    int          tag;
  } exp_t;

  vec_t vt[16];
  exp_t sbq[$];
  exp_t cur_exp[NREQ];
  exp_t mon_e;

  int n_chk = 0;
  int n_fail = 0;
  int exp_ops = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [2:0]  prev_misc;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic fail_to(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // Scoreboard: record accepted requests, match responses in order
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (prev_stall) begin
        chk("hold_data", resp_data, prev_data);
        chk("hold_id_flags", {29'd0, resp_id, resp_error, resp_overflow}, {29'd0, prev_misc});
      end
      if (resp_valid && resp_ready) begin
        chk("ops_done_count", {16'd0, ops_done}, 32'(exp_ops));
        exp_ops++;
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_resp: got id %0d data %h, none expected", resp_id, resp_data);
        end else begin
          mon_e = sbq.pop_front();
          chk($sformatf("resp_data[t%0d]", mon_e.tag), resp_data, mon_e.d);
          chk($sformatf("resp_id[t%0d]", mon_e.tag), {31'd0, resp_id}, 32'(mon_e.id));
          chk($sformatf("resp_flags[t%0d]", mon_e.tag), {30'd0, resp_error, resp_overflow},
              {30'd0, mon_e.e, mon_e.o});
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) sbq.push_back(cur_exp[i]);
      prev_stall = resp_valid && !resp_ready;
      prev_data  = resp_data;
      prev_misc  = {resp_id, resp_error, resp_overflow};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Present an operand pair on requester rq (call just after a rising edge)
  task automatic drive(input int rq, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input logic e, input logic o, input int tag);
    req_a[rq*32 +: 32] = a;
    req_b[rq*32 +: 32] = b;
    cur_exp[rq] = '{rq, d, e, o, tag};
    req_valid[rq] = 1'b1;
  endtask

  task automatic issue(input vec_t v, input int tag);
    int n;
    drive(v.rq, v.a, v.b, v.d, v.e, v.o, tag);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[v.rq]) break;
    end
    if (n == 20) fail_to($sformatf("accept[t%0d]", tag));
    @(posedge clk); #1;
    req_valid[v.rq] = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    for (n = 0; n < 20 && sbq.size() != 0; n++) begin
      @(negedge clk); #1;
    end
    if (sbq.size() != 0) begin
      fail_to(nm);
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] d_a[6];
  logic [31:0] d_p[6];

  initial begin
    int j, acc;
    logic took;

    vt[0]  = '{0, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
    vt[1]  = '{1, 32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0};
    vt[2]  = '{0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0};
    vt[3]  = '{0, 32'h7F000000, 32'h40000000, 32'h7F800000, 1'b0, 1'b1};
    vt[4]  = '{1, 32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 1'b0};
    vt[5]  = '{0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0};
    vt[6]  = '{1, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0};
    vt[7]  = '{0, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b0};
    vt[8]  = '{1, 32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0};
    vt[9]  = '{0, 32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b0};
    vt[10] = '{1, 32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 1'b0};
    vt[11] = '{0, 32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0};
    vt[12] = '{1, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0};
    vt[13] = '{0, 32'hFF000000, 32'h40000000, 32'hFF800000, 1'b0, 1'b1};
    vt[14] = '{0, 32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0};
    vt[15] = '{1, 32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0};

    d_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    d_p = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000, 32'h41200000, 32'h41400000};

    // ---- reset state, with requests pending ----
    rst_n = 1'b0;
    resp_ready = 1'b1;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    #12;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_id_flags", {29'd0, resp_id, resp_error, resp_overflow}, 32'd0);
    chk("rst_ops_done", {16'd0, ops_done}, 32'd0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- two-cycle latency on the first vector ----
    drive(vt[0].rq, vt[0].a, vt[0].b, vt[0].d, vt[0].e, vt[0].o, 0);
    @(negedge clk);
    chk("lat_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("lat_t+1_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("lat_t+2_valid", {31'd0, resp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("ops_done_first", {16'd0, ops_done}, 32'd1);

    // ---- vector table ----
    for (int i = 1; i < 16; i++) begin
      issue(vt[i], i);
      drain($sformatf("drain[t%0d]", i));
    end

    // ---- both requesters held: grants alternate 0,1,0,1 ----
    drive(0, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 100);
    drive(1, 32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 1'b0, 101);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rr_grant[%0d]", k), {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain("drain_rr");

    // ---- full stall: R0 continuously valid, resp_ready low 6 cycles ----
    resp_ready = 1'b0;
    j = 0;
    acc = 0;
    drive(0, d_a[0], 32'h40000000, d_p[0], 1'b0, 1'b0, 200);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      took = req_ready[0];
      if (took) acc++;
      @(posedge clk); #1;
      if (took) begin
        j++;
        drive(0, d_a[j], 32'h40000000, d_p[j], 1'b0, 1'b0, 200 + j);
      end
    end
    chk("stall_accepts", 32'(acc), 32'd2);
    @(negedge clk);
    chk("stall_ready", {30'd0, req_ready}, 32'd0);
    chk("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      took = req_ready[0];
      if (c == 0) chk("release_ready", {31'd0, took}, 32'd1);
      @(posedge clk); #1;
      if (took) begin
        j++;
        if (j < 6) drive(0, d_a[j], 32'h40000000, d_p[j], 1'b0, 1'b0, 200 + j);
        else req_valid[0] = 1'b0;
      end
    end
    req_valid = '0;
    chk("release_accepts", 32'(j), 32'd6);
    drain("drain_stall");
    chk("ops_done_after_stall", {16'd0, ops_done}, 32'(exp_ops));

    // ---- reset while both stages hold valid data ----
    resp_ready = 1'b0;
    drive(0, 32'h3F800000, 32'h40400000, 32'h40400000, 1'b0, 1'b0, 300);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1, 32'h3F800000, 32'h40800000, 32'h40800000, 1'b0, 1'b0, 301);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("midrst_ops_done", {16'd0, ops_done}, 32'd0);
    chk("midrst_resp_data", resp_data, 32'd0);
    sbq.delete();
    exp_ops = 0;
    drive(0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 302);
    drive(1, 32'h40800000, 32'h40400000, 32'h41400000, 1'b0, 1'b0, 303);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_grant0", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("postrst_grant1", {30'd0, req_ready}, 32'd2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain("drain_postrst");
    chk("postrst_ops_done", {16'd0, ops_done}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fmul_arbiter.md
# fmul_arbiter

Shared-multiplier front end: arbitrates up to four requesters onto one single-precision FMUL datapath. It registers the granted operand pair, runs it through the combinational FMUL core, and registers the packed IEEE-754 result with its requester ID and exception flags. The block sits between the issue logic of several consumers and one FMUL instance. It gives one multiply per cycle of throughput with full valid/ready backpressure.

## Interface
- NREQ, 2: number of requesters, legal 2..4; localparam ID_W = 1 for NREQ=2, else 2
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept, at most one bit high
- req_a  in  32*NREQ  operand A of requester i at [32i+31:32i], IEEE single
- req_b  in  32*NREQ  operand B of requester i, same packing
- resp_valid  out  1  result valid
- resp_ready  in  1  downstream accept
- resp_data  out  32  packed product {sign, exp[7:0], frac[22:0]}
- resp_id  out  ID_W  index of the requester that issued this result
- resp_error  out  1  invalid operation (inf*0 or 0*inf)
- resp_overflow  out  1  exponent overflow; result forced to inf
- ops_done  out  16  count of completed response handshakes, wraps

## Operation
- Two-stage pipeline:
  - S1 holds operands: s1_valid, a, b, id.
  - The FMUL core sits combinationally between S1 and S2.
  - S2 holds the result: s2_valid, data, error, overflow, id.
- The core is fed {sign, exp, frac} split from S1 a and b. Packed result = {core sign, core exp, core frac[23:1]}.
  - Core frac[0] is a guard bit and is dropped; rounding is truncation.
  - Core error/overflow flags are captured into S2 unchanged.
- Advance rules:
  - s2_adv = !s2_valid || resp_ready.
  - s1_adv = !s1_valid || s2_adv.
  - On s2_adv, S2 loads S1, including s1_valid, so a bubble propagates.
- Arbitration is round-robin:
  - ptr is the ID_W-bit highest-priority index.
  - Grant goes to the first i with req_valid[i], scanning ptr, ptr+1, … mod NREQ.
  - req_ready[i] = s1_adv && grant==i, combinational.
  - On a request handshake with requester g, ptr <= (g+1) mod NREQ; otherwise ptr holds.
- On s1_adv with no requester valid, S1 loads s1_valid=0.
- Requesters hold valid and operands stable until accepted. The block never drops an accepted request.
- Response rules:
  - resp_* are driven straight from S2.
  - While resp_valid && !resp_ready, all resp_* hold stable.
  - Results leave in acceptance order.
- ops_done increments on every resp_valid && resp_ready and wraps 16'hFFFF -> 0.

## Timing
- Reset (async assert, sync release):
  - s1_valid=0, s2_valid=0, ptr=0, ops_done=0.
  - resp_data=0, resp_id=0, resp_error=0, resp_overflow=0.
  - req_ready is all 0 while rst_n=0.
- Latency: request handshake at edge t gives resp_valid high from edge t+2, i.e. 2 cycles.
- Throughput: one handshake per cycle with resp_ready held high.
- Full stall: with S1 and S2 both valid and resp_ready=0, s1_adv=0 and all req_ready=0. Exactly two requests are held in flight.
- Release: the cycle resp_ready rises, S2 drains, S1 moves into S2, and a new request is accepted in the same cycle.
- Simultaneous requests: exactly one grant per cycle. Losers keep valid and win on a later cycle, with a bound of NREQ-1 cycles of starvation under continuous acceptance.
- Reset mid-operation: in-flight results are discarded and no response is produced for them. Pointer returns to 0.

## Test plan
- R0 sends 0x3FC00000 * 0x40000000 with resp_ready=1 -> two cycles later resp_data=0x40400000, resp_id=0, error=0, overflow=0; ops_done=1.
- R1 sends 0xC0000000 * 0x40400000 -> resp_data=0xC0C00000, resp_id=1. R0 sends 0x7F800000 * 0x00000000 -> resp_data=0x7FC00000, resp_error=1.
- R0 sends 0x7F000000 * 0x40000000 -> resp_data=0x7F800000, resp_overflow=1, resp_error=0.
- NREQ=2, both req_valid held high, resp_ready=1, distinct operands per request -> grants alternate 0,1,0,1 and resp_id follows the same order with matching products.
- resp_ready=0 for 6 cycles with R0 continuously valid -> exactly two accepts, then req_ready=0 with resp_data stable. On release, responses arrive in order and no request is lost or duplicated.
- Assert rst_n low while S1 and S2 are both valid -> resp_valid=0 and req_ready=0 immediately, no stale response after release; the first grant after reset goes to the lowest valid index.
